graph_point_plotter: RTL



---
 rtl/graph_point_plotter.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/graph_point_plotter.sv
// graph_point_plotter: consumer end of the 2D data-point stream.
// Buffers signed (x, y) points in a small FIFO, maps the FIFO head to screen
// space (arithmetic shift scale plus configurable origin, y axis pointing up),
// clips off-screen points and emits the rest as pixel write requests.
// A point marked pt_last produces a one-cycle frame_done pulse when it retires,
// whether it retires through a pixel handshake or through a clip.
module graph_point_plotter #(
    parameter int COORD_W    = 16,
    parameter int SCREEN_W   = 640,
    parameter int SCREEN_H   = 480,
    parameter int ADDR_W     = 19,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      pt_valid,
    output logic                      pt_ready,
    input  logic signed [COORD_W-1:0] pt_x,
    input  logic signed [COORD_W-1:0] pt_y,
    input  logic                      pt_last,
    input  logic        [3:0]         cfg_shift,
    input  logic signed [COORD_W-1:0] cfg_x_origin,
    input  logic signed [COORD_W-1:0] cfg_y_origin,
    output logic                      pix_valid,
    input  logic                      pix_ready,
    output logic        [9:0]         pix_x,
    output logic        [8:0]         pix_y,
    output logic        [ADDR_W-1:0]  pix_addr,
    output logic                      frame_done,
    output logic        [CNT_W-1:0]   plot_cnt,
    output logic        [CNT_W-1:0]   clip_cnt
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    // Two guard bits: one for the add/subtract carry, one so the sign survives.
    localparam int EXT_W = COORD_W + 2;
    localparam logic signed [EXT_W-1:0] L_SCREEN_W = EXT_W'(SCREEN_W);
    localparam logic signed [EXT_W-1:0] L_SCREEN_H = EXT_W'(SCREEN_H);

    typedef struct packed {
        logic               last;
        logic [COORD_W-1:0] y;
        logic [COORD_W-1:0] x;
    } point_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_EMIT = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // Input FIFO
    // ------------------------------------------------------------------
    point_t             r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [PTR_W:0]     r_count;
    logic               r_alive;

    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    point_t             w_head;

    assign w_full   = (r_count == (PTR_W+1)'(FIFO_DEPTH));
    assign w_empty  = (r_count == '0);
    // r_alive keeps pt_ready low while reset is held; space is judged only
    // from the registered count, so a same-cycle pop never frees a slot.
    assign pt_ready = r_alive && !w_full;
    assign w_push   = pt_valid && pt_ready;
    assign w_head   = r_mem[r_rd_ptr];

    // Point storage write port.
    // NOTE: the storage array has no reset; occupancy is tracked by r_count,
    // so stale entries are never observed and the array maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {pt_last, pt_y, pt_x};
        end
    end

    // FIFO pointers, occupancy and the out-of-reset flag.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_alive  <= 1'b0;
        end else begin
            r_alive <= 1'b1;
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Screen-space mapping of the FIFO head (config sampled at pop)
    // ------------------------------------------------------------------
    logic signed [COORD_W-1:0] w_hx_sh;
    logic signed [COORD_W-1:0] w_hy_sh;
    logic signed [EXT_W-1:0]   w_sx;
    logic signed [EXT_W-1:0]   w_sy;
    logic                      w_clip_pt;
    logic [ADDR_W-1:0]         w_addr;

    // >>> on a signed operand rounds toward minus infinity.
    assign w_hx_sh = $signed(w_head.x) >>> cfg_shift;
    assign w_hy_sh = $signed(w_head.y) >>> cfg_shift;

    assign w_sx = {{2{w_hx_sh[COORD_W-1]}}, w_hx_sh}
                + {{2{cfg_x_origin[COORD_W-1]}}, cfg_x_origin};
    // Screen rows grow downward while data y grows upward.
    assign w_sy = {{2{cfg_y_origin[COORD_W-1]}}, cfg_y_origin}
                - {{2{w_hy_sh[COORD_W-1]}}, w_hy_sh};

    assign w_clip_pt = w_sx[EXT_W-1] || (w_sx >= L_SCREEN_W)
                    || w_sy[EXT_W-1] || (w_sy >= L_SCREEN_H);

    // Only meaningful for in-range points, where the low bits hold the value.
    assign w_addr = ADDR_W'(w_sy[8:0]) * ADDR_W'(SCREEN_W) + ADDR_W'(w_sx[9:0]);

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    state_t r_state;
    state_t w_state_nxt;
    logic   w_load;
    logic   w_clip;
    logic   w_hs;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, pop/load/clip decisions and pixel handshake detect.
    // NOTE: every output gets a default first so no path infers a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_load      = 1'b0;
        w_clip      = 1'b0;
        w_hs        = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop = 1'b1;
                    if (w_clip_pt) begin
                        w_clip = 1'b1;
                    end else begin
                        w_load      = 1'b1;
                        w_state_nxt = S_EMIT;
                    end
                end
            end
            S_EMIT: begin
                if (pix_ready) begin
                    w_hs        = 1'b1;
                    w_state_nxt = S_IDLE;
                    // Back-to-back: the next head is judged in the same cycle.
                    if (!w_empty) begin
                        w_pop = 1'b1;
                        if (w_clip_pt) begin
                            w_clip = 1'b1;
                        end else begin
                            w_load      = 1'b1;
                            w_state_nxt = S_EMIT;
                        end
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Pixel output register, frame delimiting and counters
    // ------------------------------------------------------------------
    logic [9:0]        r_pix_x;
    logic [8:0]        r_pix_y;
    logic [ADDR_W-1:0] r_pix_addr;
    logic              r_pix_last;
    logic              r_frame_done;
    logic [CNT_W-1:0]  r_plot_cnt;
    logic [CNT_W-1:0]  r_clip_cnt;

    // Capture the mapped pixel on load; it stays put until the next load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pix_x    <= '0;
            r_pix_y    <= '0;
            r_pix_addr <= '0;
            r_pix_last <= 1'b0;
        end else if (w_load) begin
            r_pix_x    <= w_sx[9:0];
            r_pix_y    <= w_sy[8:0];
            r_pix_addr <= w_addr;
            r_pix_last <= w_head.last;
        end
    end

    // Frame pulse and saturating plot/clip counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_done <= 1'b0;
            r_plot_cnt   <= '0;
            r_clip_cnt   <= '0;
        end else begin
            r_frame_done <= (w_clip && w_head.last) || (w_hs && r_pix_last);
            if (w_hs && (r_plot_cnt != '1)) r_plot_cnt <= r_plot_cnt + 1'b1;
            if (w_clip && (r_clip_cnt != '1)) r_clip_cnt <= r_clip_cnt + 1'b1;
        end
    end

    assign pix_valid  = (r_state == S_EMIT);
    assign pix_x      = r_pix_x;
    assign pix_y      = r_pix_y;
    assign pix_addr   = r_pix_addr;
    assign frame_done = r_frame_done;
    assign plot_cnt   = r_plot_cnt;
    assign clip_cnt   = r_clip_cnt;

endmodule
